// File: rtl/if_id_buf.sv
// Two-entry skid FIFO between fetch and decode; the head entry is presented to decode.
// Optional build macro IF_ID_BUF_PERF_EN adds the stall_cnt fetch-stall counter.
module if_id_buf #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_flush,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    input  logic [XLEN-1:0] if_inst,
    input  logic            if_inst_addr_misal,
    output logic            if_allowin,
    input  logic            id_allowin,
    output logic            if_id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_inst,
    output logic            if2id_inst_addr_misal,
`ifdef IF_ID_BUF_PERF_EN
    output logic [31:0]     stall_cnt,
`endif
    output logic [1:0]      buf_cnt
);

    logic [XLEN-1:0] r_pc    [2];
    logic [XLEN-1:0] r_inst  [2];
    logic            r_misal [2];
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [1:0]      r_cnt;

    logic            w_push;
    logic            w_pop;
    logic            w_nonempty;

    // Handshake depends only on registered count, so id_allowin never reaches if_allowin.
    assign w_nonempty  = (r_cnt != 2'd0);
    assign if_allowin  = (r_cnt != 2'd2);
    assign if_id_valid = w_nonempty;
    assign buf_cnt     = r_cnt;
    assign w_push      = if_valid && if_allowin;
    assign w_pop       = w_nonempty && id_allowin;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= 2'd0;
        end else if (pipe_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // A push coinciding with a flush is dropped, so storage is left untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_pc[i]    <= '0;
                r_inst[i]  <= '0;
                r_misal[i] <= 1'b0;
            end
        end else if (w_push && !pipe_flush) begin
            r_pc[r_wr_ptr]    <= if_pc;
            r_inst[r_wr_ptr]  <= if_inst;
            r_misal[r_wr_ptr] <= if_inst_addr_misal;
        end
    end

    always_comb begin
        id_pc                 = '0;
        id_inst               = '0;
        if2id_inst_addr_misal = 1'b0;
        if (w_nonempty) begin
            id_pc                 = r_pc[r_rd_ptr];
            id_inst               = r_inst[r_rd_ptr];
            if2id_inst_addr_misal = r_misal[r_rd_ptr];
        end
    end

`ifdef IF_ID_BUF_PERF_EN
    logic [31:0] r_stall_cnt;

    // Cleared by reset only; a flush keeps the running total.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'd0;
        end else if (if_valid && !if_allowin) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
